// File: rtl/sha_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha_pkg
// Description : Shared constants, state encoding and rotate helper for the
//               SHA-256 message schedule controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sha_pkg;

  // Word width of the SHA-256 datapath (fixed by the algorithm)
  localparam int WORD_W = 32;

  // Small-sigma rotate / shift amounts
  localparam int unsigned S0_R1 = 7;
  localparam int unsigned S0_R2 = 18;
  localparam int unsigned S0_SH = 3;
  localparam int unsigned S1_R1 = 17;
  localparam int unsigned S1_R2 = 19;
  localparam int unsigned S1_SH = 10;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Rotate right by a constant amount (n must be 1..WORD_W-1)
  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned       n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_small_sigma.sv
`default_nettype none
// ============================================================================
// Module      : sha256_small_sigma
// Description : SHA-256 small sigma: rotr(R1) ^ rotr(R2) ^ shr(SH).
//               Instantiated once as sigma0 and once as sigma1.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_small_sigma
  import sha_pkg::*;
#(
  parameter int unsigned R1 = 7,
  parameter int unsigned R2 = 18,
  parameter int unsigned SH = 3
) (
  input  logic [WORD_W-1:0] i_x,
  output logic [WORD_W-1:0] o_y
);

  // Pure combinational mix; amounts are elaboration-time constants
  assign o_y = rotr(i_x, R1) ^ rotr(i_x, R2) ^ (i_x >> SH);

endmodule
`default_nettype wire

// File: rtl/sha256_msg_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_sched_ctrl
// Description : Loads 16 message words into a circular buffer, then streams
//               W[0..NUM_W-1], computing W[16..] in place in the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_sched_ctrl
  import sha_pkg::*;
#(
  parameter int NUM_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [WORD_W-1:0] i_in_data,
  output logic              o_w_valid,
  input  logic              i_w_ready,
  output logic [WORD_W-1:0] o_w_data,
  output logic [5:0]        o_w_idx
);

  localparam logic [5:0] LAST_T = 6'(NUM_W - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [5:0]        r_t;
  logic              r_busy;
  logic              r_done;
  logic              r_in_ready;
  logic              r_w_valid;
  logic [WORD_W-1:0] r_buf [16];

  logic              w_in_fire;
  logic              w_w_fire;
  logic              w_is_calc;
  logic [3:0]        w_ix2;
  logic [3:0]        w_ix7;
  logic [3:0]        w_ix15;
  logic [3:0]        w_ix16;
  logic [WORD_W-1:0] w_sig0_in;
  logic [WORD_W-1:0] w_sig1_in;
  logic [WORD_W-1:0] w_sig0;
  logic [WORD_W-1:0] w_sig1;
  logic [WORD_W-1:0] w_calc;

  assign w_in_fire = i_in_valid && r_in_ready;
  assign w_w_fire  = r_w_valid && i_w_ready;
  assign w_is_calc = (r_t[5:4] != 2'b00);

  // Buffer slots relative to t, modulo 16; (t-16)%16 is simply t%16
  assign w_ix2  = r_t[3:0] - 4'd2;
  assign w_ix7  = r_t[3:0] - 4'd7;
  assign w_ix15 = r_t[3:0] - 4'd15;
  assign w_ix16 = r_t[3:0];

  assign w_sig0_in = r_buf[w_ix15];
  assign w_sig1_in = r_buf[w_ix2];

  sha256_small_sigma #(.R1(S0_R1), .R2(S0_R2), .SH(S0_SH)) u_sigma0 (
    .i_x (w_sig0_in),
    .o_y (w_sig0)
  );

  sha256_small_sigma #(.R1(S1_R1), .R2(S1_R2), .SH(S1_SH)) u_sigma1 (
    .i_x (w_sig1_in),
    .o_y (w_sig1)
  );

  assign w_calc = w_sig1 + r_buf[w_ix7] + w_sig0 + r_buf[w_ix16];

  // Outputs: flags are registered; data is a mux over registered state only,
  // so it holds steady while the consumer stalls
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_in_ready = r_in_ready;
  assign o_w_valid  = r_w_valid;
  assign o_w_idx    = r_t;
  assign o_w_data   = r_w_valid ? (w_is_calc ? w_calc : r_buf[w_ix16]) : '0;

  // Control FSM: sequences LOAD -> EMIT -> DONE with registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_t        <= 6'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_in_ready <= 1'b0;
      r_w_valid  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state    <= ST_LOAD;
            r_cnt      <= 4'd0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_in_fire) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_state    <= ST_EMIT;
              r_t        <= 6'd0;
              r_in_ready <= 1'b0;
              r_w_valid  <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (w_w_fire) begin
            if (r_t == LAST_T) begin
              r_state   <= ST_DONE;
              r_t       <= 6'd0;
              r_w_valid <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_t <= r_t + 6'd1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Circular buffer: loaded in LOAD, computed word written back to slot t%16
  // on the same edge that consumes its W[t-16] operand
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_in_fire) begin
        r_buf[r_cnt] <= i_in_data;
      end else if (w_w_fire && w_is_calc) begin
        r_buf[w_ix16] <= w_calc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_msg_sched_ctrl
// Description : Scoreboard bench for the SHA-256 message schedule controller,
//               using the padded "abc" block; a second instance is built
//               with NUM_W=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_sched_ctrl;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start16;
  logic        in_valid;
  logic [31:0] in_data;
  logic        w_ready;

  logic        busy_a, done_a, in_ready_a, w_valid_a;
  logic [31:0] w_data_a;
  logic [5:0]  w_idx_a;
  logic        busy_b, done_b, in_ready_b, w_valid_b;
  logic [31:0] w_data_b;
  logic [5:0]  w_idx_b;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];

  logic        tog_en = 1'b0;
  logic [3:0]  tog_pat = 4'b1001;
  int          tog_k = 0;

  logic        hold_a = 1'b0;
  logic [31:0] hd_a;
  logic [5:0]  hi_a;

  sha256_msg_sched_ctrl #(.NUM_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .o_busy     (busy_a),
    .o_done     (done_a),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready_a),
    .i_in_data  (in_data),
    .o_w_valid  (w_valid_a),
    .i_w_ready  (w_ready),
    .o_w_data   (w_data_a),
    .o_w_idx    (w_idx_a)
  );

  sha256_msg_sched_ctrl #(.NUM_W(16)) dut16 (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start16),
    .o_busy     (busy_b),
    .o_done     (done_b),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready_b),
    .i_in_data  (in_data),
    .o_w_valid  (w_valid_b),
    .i_w_ready  (w_ready),
    .o_w_data   (w_data_b),
    .o_w_idx    (w_idx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (time %0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule over a flat array, with the published "abc" words pinned
  task automatic build_expected();
    for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
    for (int t = 16; t < 64; t++)
      exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
    exp_w[16] = 32'h61626380;
    exp_w[17] = 32'h000F0000;
    exp_w[18] = 32'h7DA86405;
    exp_w[19] = 32'h600003C6;
    exp_w[63] = 32'h12B1EDEB;
  endtask

  // w_ready driver: constant 1, or the 1,0,0,1 pattern when enabled
  initial begin
    w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) begin
        w_ready = tog_pat[tog_k];
        tog_k   = (tog_k + 1) % 4;
      end else begin
        w_ready = 1'b1;
      end
    end
  end

  // Monitor for the 64-word instance: scoreboard pop plus stall stability
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_a = 1'b0;
    end else begin
      if (hold_a && w_valid_a) begin
        chk("hold_w_data", w_data_a, hd_a);
        chk("hold_w_idx", {26'd0, w_idx_a}, {26'd0, hi_a});
      end
      if (w_valid_a && w_ready) begin
        if (q_a.size() == 0) begin
          chk("unexpected_w_a", {26'd0, w_idx_a}, 32'hFFFFFFFF);
        end else begin
          e = q_a.pop_front();
          chk($sformatf("w_data_a[%0d]", e.idx), w_data_a, e.data);
          chk("w_idx_a", {26'd0, w_idx_a}, {26'd0, e.idx});
        end
      end
      hold_a = w_valid_a && !w_ready;
      hd_a   = w_data_a;
      hi_a   = w_idx_a;
      if (done_a) done_cnt_a++;
    end
  end

  // Monitor for the NUM_W=16 instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (w_valid_b && w_ready) begin
        if (q_b.size() == 0) begin
          chk("unexpected_w_b", {26'd0, w_idx_b}, 32'hFFFFFFFF);
        end else begin
          e = q_b.pop_front();
          chk($sformatf("w_data_b[%0d]", e.idx), w_data_b, e.data);
          chk("w_idx_b", {26'd0, w_idx_b}, {26'd0, e.idx});
        end
      end
      if (done_b) done_cnt_b++;
    end
  end

  task automatic push_a();
    for (int t = 0; t < 64; t++) q_a.push_back('{idx: 6'(t), data: exp_w[t]});
  endtask

  task automatic push_b();
    for (int t = 0; t < 16; t++) q_b.push_back('{idx: 6'(t), data: blk[t]});
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},     {31'd0, busy_a},     32'd0);
    chk({tag, "_done"},     {31'd0, done_a},     32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready_a}, 32'd0);
    chk({tag, "_w_valid"},  {31'd0, w_valid_a},  32'd0);
    chk({tag, "_w_data"},   w_data_a,            32'd0);
    chk({tag, "_w_idx"},    {26'd0, w_idx_a},    32'd0);
  endtask

  // Pulse start (drive phase is posedge+1 throughout)
  task automatic do_start(input logic with16);
    start   = 1'b1;
    start16 = with16;
    @(posedge clk); #1;
    start   = 1'b0;
    start16 = 1'b0;
  endtask

  // Feed the 16 words, idling `gap` cycles before each one
  task automatic load_block(input int gap, input logic with16);
    int n;
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_gap", {31'd0, in_ready_a}, 32'd1);
      end
      in_valid = 1'b1;
      in_data  = blk[i];
      n = 0;
      while (!in_ready_a && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      chk("in_ready_load", {31'd0, in_ready_a}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 32'hDEADBEEF;
    chk("first_w_valid", {31'd0, w_valid_a}, 32'd1);
    chk("first_w_idx",   {26'd0, w_idx_a},   32'd0);
    chk("in_ready_after_load", {31'd0, in_ready_a}, 32'd0);
    if (with16) chk("first_w_valid_b", {31'd0, w_valid_b}, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_a && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", {31'd0, done_a}, 32'd1);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic wait_idx(input logic [5:0] idx);
    int n = 0;
    while (!(w_valid_a && w_idx_a == idx) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_idx", {26'd0, w_idx_a}, {26'd0, idx});
  endtask

  initial begin
    int dc;
    rst      = 1'b1;
    start    = 1'b0;
    start16  = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'd0;
    blk[0]  = 32'h61626380;
    for (int i = 1; i < 15; i++) blk[i] = 32'd0;
    blk[15] = 32'h00000018;
    build_expected();

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_outputs("reset");
    chk("reset_b_busy",    {31'd0, busy_b},    32'd0);
    chk("reset_b_w_valid", {31'd0, w_valid_b}, 32'd0);

    // Block A: back-to-back, both instances
    push_a();
    push_b();
    do_start(1'b1);
    load_block(0, 1'b1);
    wait_done(200);
    chk("done_cnt_a_A", done_cnt_a, 1);
    chk("done_cnt_b_A", done_cnt_b, 1);
    chk("q_b_empty_A", q_b.size(), 0);
    chk("q_a_empty_A", q_a.size(), 0);

    // Block B: consumer stalls with 1,0,0,1 pattern
    push_a();
    tog_en = 1'b1;
    do_start(1'b0);
    load_block(0, 1'b0);
    wait_done(400);
    tog_en = 1'b0;
    chk("done_cnt_a_B", done_cnt_a, 2);
    chk("q_a_empty_B", q_a.size(), 0);

    // Block C: input word every third cycle
    push_a();
    do_start(1'b0);
    load_block(2, 1'b0);
    wait_done(200);
    chk("done_cnt_a_C", done_cnt_a, 3);
    chk("q_a_empty_C", q_a.size(), 0);

    // Block D: reset at t=30, then a fresh block
    push_a();
    do_start(1'b0);
    load_block(0, 1'b0);
    wait_idx(6'd30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q_a.delete();
    check_idle_outputs("mid_rst");
    repeat (3) @(posedge clk);
    #1;
    chk("done_cnt_after_rst", done_cnt_a, 3);
    check_idle_outputs("post_rst");
    push_a();
    do_start(1'b0);
    load_block(0, 1'b0);
    wait_done(200);
    chk("done_cnt_a_D", done_cnt_a, 4);
    chk("q_a_empty_D", q_a.size(), 0);

    // Block E: in_valid in IDLE and start during EMIT are ignored
    in_valid = 1'b1;
    in_data  = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_idle_outputs("idle_in_valid");
    end
    in_valid = 1'b0;
    push_a();
    do_start(1'b0);
    load_block(0, 1'b0);
    wait_idx(6'd20);
    start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start_in_emit", {31'd0, busy_a}, 32'd1);
    chk("in_ready_after_start_in_emit", {31'd0, in_ready_a}, 32'd0);
    wait_done(200);
    dc = done_cnt_a;
    chk("done_cnt_a_E", dc, 5);
    repeat (4) @(posedge clk);
    #1;
    check_idle_outputs("after_E");
    chk("done_cnt_final", done_cnt_a, 5);
    chk("q_a_empty_E", q_a.size(), 0);
    chk("done_cnt_b_final", done_cnt_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if the bench ever stalls
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
